// File: rtl/cmp_hazard_scoreboard_if.sv
// D-stage hazard scoreboard bundle: decoded operand info in,
// stall decision and operand forward selects out.
interface cmp_hazard_scoreboard_if #(
  parameter int STALL_CNT_W = 32
);
  logic                   flush;
  logic                   D_valid;
  logic [4:0]             D_rs;
  logic [4:0]             D_rt;
  logic                   D_rs_use;
  logic                   D_rt_use;
  logic [1:0]             D_rs_tuse;
  logic [1:0]             D_rt_tuse;
  logic [4:0]             D_wa;
  logic [1:0]             D_tnew;
  logic                   stall;
  logic [1:0]             fwd_rs_sel;
  logic [1:0]             fwd_rt_sel;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output flush, D_valid,
    output D_rs, D_rt,
    output D_rs_use, D_rt_use,
    output D_rs_tuse, D_rt_tuse,
    output D_wa, D_tnew,
    input  stall, fwd_rs_sel,
    input  fwd_rt_sel, stall_cycles
  );

  modport slave (
    input  flush, D_valid,
    input  D_rs, D_rt,
    input  D_rs_use, D_rt_use,
    input  D_rs_tuse, D_rt_tuse,
    input  D_wa, D_tnew,
    output stall, fwd_rs_sel,
    output fwd_rt_sel, stall_cycles
  );
endinterface

// File: rtl/cmp_hazard_scoreboard.sv
// Tnew/Tuse scoreboard for the D stage: shadow E/M/W writer slots,
// stall decision and D-stage operand forward selects.
module cmp_hazard_scoreboard #(
  parameter int STALL_CNT_W = 32
) (
  input logic clk,
  input logic reset,
  cmp_hazard_scoreboard_if.slave hz
);

  typedef struct packed {
    logic       v;
    logic [4:0] wa;
    logic [1:0] tn;
  } slot_t;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

  slot_t e_q, e_d;
  slot_t m_q, m_d;
  slot_t w_q, w_d;

  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic       rs_act, rt_act;
  logic [2:0] rs_res, rt_res;
  logic       stall;

  function automatic slot_t age(slot_t s);
    slot_t o;
    o = s;
    if (s.tn != 2'd0) o.tn = s.tn - 2'd1;
    return o;
  endfunction

  // result = {hazard, sel}; youngest matching slot decides
  function automatic logic [2:0] resolve(
    logic       act,
    logic [4:0] r,
    logic [1:0] tuse,
    slot_t      e,
    slot_t      m,
    slot_t      w
  );
    slot_t      hit;
    logic [1:0] idx;
    logic       found;
    logic [2:0] res;
    hit   = '0;
    idx   = 2'd0;
    found = 1'b0;
    res   = 3'b000;
    if (e.v && e.wa == r) begin
      hit = e; idx = 2'd1; found = 1'b1;
    end else if (m.v && m.wa == r) begin
      hit = m; idx = 2'd2; found = 1'b1;
    end else if (w.v && w.wa == r) begin
      hit = w; idx = 2'd3; found = 1'b1;
    end
    if (act && found) begin
      if (hit.tn > tuse) res = 3'b100;
      else if (hit.tn == 2'd0) res = {1'b0, idx};
    end
    return res;
  endfunction

  always_comb begin
    rs_act = hz.D_valid & hz.D_rs_use
           & (|hz.D_rs);
    rt_act = hz.D_valid & hz.D_rt_use
           & (|hz.D_rt);
    rs_res = resolve(rs_act, hz.D_rs,
                     hz.D_rs_tuse,
                     e_q, m_q, w_q);
    rt_res = resolve(rt_act, hz.D_rt,
                     hz.D_rt_tuse,
                     e_q, m_q, w_q);
    stall  = rs_res[2] | rt_res[2];
  end

  always_comb begin
    e_d = '0;
    m_d = age(e_q);
    w_d = age(m_q);
    if (hz.D_valid && !stall
        && hz.D_wa != 5'd0) begin
      e_d.v  = 1'b1;
      e_d.wa = hz.D_wa;
      e_d.tn = hz.D_tnew;
    end
    if (hz.flush) begin
      e_d = '0;
      m_d = '0;
      w_d = '0;
    end
    cnt_d = cnt_q;
    if (stall && cnt_q != '1)
      cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign hz.stall        = stall;
  assign hz.fwd_rs_sel   = rs_res[1:0];
  assign hz.fwd_rt_sel   = rt_res[1:0];
  assign hz.stall_cycles = cnt_q;

endmodule

// File: tb/tb_cmp_hazard_scoreboard.sv
// Scoreboard bench for cmp_hazard_scoreboard: per-cycle expected
// stall/select/counter values queued at drive, popped at negedge.
module tb_cmp_hazard_scoreboard;

  localparam int W    = 2;
  localparam int CMAX = 3;

  typedef struct {
    string      tag;
    logic       st;
    logic [1:0] rs;
    logic [1:0] rt;
    int         cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_cnt;
  exp_t exp_q[$];

  cmp_hazard_scoreboard_if #(.STALL_CNT_W(W)) bus ();

  cmp_hazard_scoreboard #(
    .STALL_CNT_W(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".stall"},
            32'(bus.stall), 32'(e.st));
      check({e.tag, ".rs_sel"},
            32'(bus.fwd_rs_sel), 32'(e.rs));
      check({e.tag, ".rt_sel"},
            32'(bus.fwd_rt_sel), 32'(e.rt));
      check({e.tag, ".cnt"},
            32'(bus.stall_cycles), e.cnt);
    end
  end

  // one D-stage cycle: operands, writer, control, expected outputs
  task automatic step(
    string tag, logic v,
    logic [4:0] rs, logic rsu, logic [1:0] rsk,
    logic [4:0] rt, logic rtu, logic [1:0] rtk,
    logic [4:0] wa, logic [1:0] tn,
    logic fl, logic rst,
    logic es, logic [1:0] ers, logic [1:0] ert
  );
    exp_t e;
    @(posedge clk);
    #1;
    bus.D_valid   = v;
    bus.D_rs      = rs;
    bus.D_rs_use  = rsu;
    bus.D_rs_tuse = rsk;
    bus.D_rt      = rt;
    bus.D_rt_use  = rtu;
    bus.D_rt_tuse = rtk;
    bus.D_wa      = wa;
    bus.D_tnew    = tn;
    bus.flush     = fl;
    reset         = rst;
    e.tag = tag;
    e.st  = es;
    e.rs  = ers;
    e.rt  = ert;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    if (rst) exp_cnt = 0;
    else if (es && exp_cnt < CMAX)
      exp_cnt++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step("idle", 0, 0, 0, 0, 0, 0, 0,
           0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    exp_cnt       = 0;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.D_valid   = 1'b0;
    bus.D_rs      = '0;
    bus.D_rt      = '0;
    bus.D_rs_use  = 1'b0;
    bus.D_rt_use  = 1'b0;
    bus.D_rs_tuse = '0;
    bus.D_rt_tuse = '0;
    bus.D_wa      = '0;
    bus.D_tnew    = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    idle(1);

    // lw $1 ; beq $1,$2
    step("lw1", 1, 0, 0, 0, 0, 0, 0,
         1, 2, 0, 0, 0, 0, 0);
    step("beq1a", 1, 1, 1, 0, 2, 1, 0,
         0, 0, 0, 0, 1, 0, 0);
    step("beq1b", 1, 1, 1, 0, 2, 1, 0,
         0, 0, 0, 0, 1, 0, 0);
    step("beq1c", 1, 1, 1, 0, 2, 1, 0,
         0, 0, 0, 0, 0, 3, 0);
    idle(3);

    // addu $3 ; bne $3,$3
    step("addu3", 1, 0, 0, 0, 0, 0, 0,
         3, 1, 0, 0, 0, 0, 0);
    step("bne3a", 1, 3, 1, 0, 3, 1, 0,
         0, 0, 0, 0, 1, 0, 0);
    step("bne3b", 1, 3, 1, 0, 3, 1, 0,
         0, 0, 0, 0, 0, 2, 2);
    idle(3);

    // jal ; beq $31,$0
    step("jal", 1, 0, 0, 0, 0, 0, 0,
         31, 0, 0, 0, 0, 0, 0);
    step("beq31", 1, 31, 1, 0, 0, 1, 0,
         0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // lw $4 ; sw $4 held in D across E/M/W
    step("lw4", 1, 0, 0, 0, 0, 0, 0,
         4, 2, 0, 0, 0, 0, 0);
    step("sw4e", 1, 29, 1, 1, 4, 1, 2,
         0, 0, 0, 0, 0, 0, 0);
    step("sw4m", 1, 29, 1, 1, 4, 1, 2,
         0, 0, 0, 0, 0, 0, 0);
    step("sw4w", 1, 29, 1, 1, 4, 1, 2,
         0, 0, 0, 0, 0, 0, 3);
    idle(3);

    // addu $5 twice ; beq $5 -> younger writer wins
    step("addu5a", 1, 0, 0, 0, 0, 0, 0,
         5, 1, 0, 0, 0, 0, 0);
    step("addu5b", 1, 5, 1, 1, 0, 0, 0,
         5, 1, 0, 0, 0, 0, 0);
    step("beq5a", 1, 5, 1, 0, 0, 1, 0,
         0, 0, 0, 0, 1, 0, 0);
    step("beq5b", 1, 5, 1, 0, 0, 1, 0,
         0, 0, 0, 0, 0, 2, 0);
    idle(3);

    // writer to $0 ; reader of $0
    step("wa0", 1, 0, 0, 0, 0, 0, 0,
         0, 2, 0, 0, 0, 0, 0);
    step("rd0", 1, 0, 1, 0, 0, 1, 0,
         0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // D_valid gates operand checks
    step("lw7", 1, 0, 0, 0, 0, 0, 0,
         7, 2, 0, 0, 0, 0, 0);
    step("beq7nv", 0, 7, 1, 0, 7, 1, 0,
         0, 0, 0, 0, 0, 0, 0);
    step("beq7m", 1, 7, 1, 0, 0, 0, 0,
         0, 0, 0, 0, 1, 0, 0);
    step("beq7w", 1, 7, 1, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 3, 0);
    idle(3);

    // flush during first stall cycle
    step("lw6f", 1, 0, 0, 0, 0, 0, 0,
         6, 2, 0, 0, 0, 0, 0);
    step("beq6fl", 1, 6, 1, 0, 0, 0, 0,
         0, 0, 1, 0, 1, 0, 0);
    step("beq6a", 1, 6, 1, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 0, 0);
    step("beq6b", 1, 6, 1, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // reset during first stall cycle
    step("lw6r", 1, 0, 0, 0, 0, 0, 0,
         6, 2, 0, 0, 0, 0, 0);
    step("beq6rs", 1, 6, 1, 0, 0, 0, 0,
         0, 0, 0, 1, 1, 0, 0);
    step("beq6c", 1, 6, 1, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0)
      check("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_hazard_scoreboard.md
# cmp_hazard_scoreboard

Tracks in-flight register writers for the D stage and decides, every cycle, whether the instruction in D must stall and where each of its two source operands is forwarded from. It serves the D-stage branch comparator, which needs operands at Tuse=0, as well as later-stage consumers. It sits beside the pipeline registers and keeps its own E/M/W shadow slots: writer address plus remaining Tnew. The top level drives the D/E pipeline enables from `stall`, and the D-stage operand muxes from the forward selects.

## Interface
Parameters:
- `STALL_CNT_W`, 32: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `flush`  in  1  exception/eret pipeline flush; synchronously invalidates all slots.
- `D_valid`  in  1  D holds a real instruction.
- `D_rs`, `D_rt`  in  5 each  source register numbers.
- `D_rs_use`, `D_rt_use`  in  1 each  operand actually read.
- `D_rs_tuse`, `D_rt_tuse`  in  2 each  cycles until the operand is consumed: 0 for beq/bne in D, 1 for ALU in E, 2 for store data in M.
- `D_wa`  in  5  destination register; 0 means no write.
- `D_tnew`  in  2  Tnew on entry to E: 0 for jal link, 1 for ALU, 2 for load.
- `stall`  out  1  freeze PC/D, insert bubble into E.
- `fwd_rs_sel`, `fwd_rt_sel`  out  2 each  0=GRF, 1=E result, 2=M result, 3=W result.
- `stall_cycles`  out  STALL_CNT_W  saturating count of cycles with `stall`=1.

## Operation
- State: three slots E, M, W, each holding {valid, wa[4:0], tnew[1:0]}.
- Slot advance every cycle, whether or not a stall is active:
  - W <= M, M <= E.
  - tnew is decremented, saturating at 0, on each move.
- E load:
  - If `D_valid` & !`stall` & `D_wa`!=0: E <= {1, D_wa, D_tnew}.
  - Otherwise E <= bubble (valid=0).
- `flush`=1: all three slots <= invalid. This takes priority over the advance and the E load.
- Operand check (combinational from slots and D inputs), applied to rs and rt independently:
  - The operand is active only when use=1, reg!=0 and `D_valid`=1.
  - Match the youngest valid slot with wa==reg, priority E > M > W.
  - No match or inactive: sel=0, no hazard.
  - Match with slot.tnew > tuse: hazard.
  - Match with slot.tnew==0: sel = slot index (E=1, M=2, W=3).
  - Match with 0 < tnew <= tuse: sel=0, no hazard. The value is forwarded downstream.
- `stall` = hazard(rs) | hazard(rt). It is a pure function of registered slots and D inputs and is evaluated in the same cycle.
- `stall_cycles` increments by 1 on each cycle with `stall`=1 and holds at all-ones.
- All arithmetic is unsigned. Tnew never goes negative.

## Timing
- Reset values: all slots invalid, `stall`=0, both selects=0, `stall_cycles`=0.
- Latency: a writer accepted into D at cycle n is visible in slot E at cycle n+1, M at n+2, W at n+3.
- Stall penalty for a following branch:
  - After a load: 2 cycles.
  - After an ALU op: 1 cycle.
  - After jal: 0 cycles, forwarded from E.
- Reset or flush asserted mid-hazard: `stall` drops in the cycle after the edge. `stall_cycles` is cleared by reset only.
- When `stall`=1 and `flush`=1 in the same cycle, the bubble and the flush coincide; slots end invalid.
- Writes to $0 never occupy a slot, so an operand of $0 never forwards or stalls.

## Test plan
- lw $1 (tnew 2), then beq $1,$2 (tuse 0): `stall`=1 for exactly 2 cycles, then `fwd_rs_sel`=3 with `stall`=0; `stall_cycles`=2.
- addu $3, then bne $3,$3: 1 stall cycle, then both selects=2 in the same cycle.
- jal (wa 31, tnew 0), then beq $31,$0: no stall, `fwd_rs_sel`=1, `fwd_rt_sel`=0.
- lw $4, then sw $4 as rt with tuse 2: no stall, `fwd_rt_sel`=0 while the producer is in E and M, then 3 at W.
- Same register written in M and E, e.g. addu $5 then addu $5 then beq $5: the E slot wins; assert 1 stall then sel=2 for the younger writer. Additionally, D_wa=0 writers never stall.
- lw $6 followed by beq $6 with `flush` pulsed during the first stall cycle: `stall`=0 the next cycle and sel=0. Repeat with `reset` and check that all outputs, including `stall_cycles`, return to 0.
